quad_encoder_emulator: RTL and testbench



---
 rtl/quad_encoder_emulator.sv | 119 +++++++++++
 tb/tb_quad_encoder_emulator.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns a commanded step period and direction into A/B/index
// waveforms, with a per-revolution position counter driving the index pulse.
module quad_encoder_emulator #(
    parameter int unsigned K_PERIOD_W = 16,
    parameter int unsigned K_POS_W    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_reverse,
    input  logic [K_PERIOD_W-1:0] i_period,
    input  logic                  i_polarity,
    input  logic [K_POS_W-1:0]    i_steps_per_rev,
    output logic                  o_a,
    output logic                  o_b,
    output logic                  o_i,
    output logic                  o_step,
    output logic                  o_step_rev,
    output logic [K_POS_W-1:0]    o_position
);

    localparam logic [K_PERIOD_W-1:0] PeriodOne = K_PERIOD_W'(1);
    localparam logic [K_POS_W-1:0]    PosOne    = K_POS_W'(1);

    logic [K_PERIOD_W-1:0] cnt_q, cnt_d;
    logic                  qa_q, qa_d;
    logic                  qb_q, qb_d;
    logic [K_POS_W-1:0]    pos_q, pos_d;
    logic                  idx_q, idx_d;
    logic                  step_q, step_d;
    logic                  step_rev_q, step_rev_d;

    logic                  running;
    logic                  step_evt;
    logic [K_POS_W-1:0]    last_pos;
    logic                  rev_enabled;
    logic [K_POS_W-1:0]    pos_next;

    // The >= compare fires immediately when the period shrinks below the running count.
    always_comb begin
        running  = i_enable && (i_period != '0);
        step_evt = running && (cnt_q >= (i_period - PeriodOne));
        if (!running || step_evt) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PeriodOne;
        end
    end

    // Forward walks 00->10->11->01; when A==B the next forward step toggles A, otherwise B.
    // Reverse is the mirror: A==B toggles B, otherwise A.
    always_comb begin
        qa_d = qa_q;
        qb_d = qb_q;
        if (step_evt) begin
            if ((qa_q == qb_q) ^ i_reverse) begin
                qa_d = ~qa_q;
            end else begin
                qb_d = ~qb_q;
            end
        end
    end

    always_comb begin
        rev_enabled = (i_steps_per_rev != '0);
        last_pos    = i_steps_per_rev - PosOne;
        pos_next    = pos_q;
        if (!rev_enabled) begin
            pos_next = i_reverse ? (pos_q - PosOne) : (pos_q + PosOne);
        end else if (!i_reverse) begin
            pos_next = (pos_q >= last_pos) ? '0 : (pos_q + PosOne);
        end else begin
            // Out-of-range positions (after N was reduced) land on the last valid slot.
            pos_next = ((pos_q == '0) || (pos_q >= i_steps_per_rev)) ? last_pos
                                                                     : (pos_q - PosOne);
        end
    end

    always_comb begin
        pos_d      = pos_q;
        idx_d      = idx_q;
        step_d     = step_evt;
        step_rev_d = step_rev_q;
        if (step_evt) begin
            pos_d      = pos_next;
            idx_d      = (pos_next == '0) && rev_enabled;
            step_rev_d = i_reverse;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            qa_q       <= 1'b0;
            qb_q       <= 1'b0;
            pos_q      <= '0;
            idx_q      <= 1'b0;
            step_q     <= 1'b0;
            step_rev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            qa_q       <= qa_d;
            qb_q       <= qb_d;
            pos_q      <= pos_d;
            idx_q      <= idx_d;
            step_q     <= step_d;
            step_rev_q <= step_rev_d;
        end
    end

    // Polarity only remaps the pins; internal state is polarity-agnostic.
    assign o_a        = i_polarity ? qb_q : qa_q;
    assign o_b        = i_polarity ? qa_q : qb_q;
    assign o_i        = idx_q;
    assign o_step     = step_q;
    assign o_step_rev = step_rev_q;
    assign o_position = pos_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Self-checking bench for quad_encoder_emulator: directed scenarios plus randomized stimulus,
// all compared every cycle against a behavioural phase/position model.
module tb_quad_encoder_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        rev;
    logic [15:0] period;
    logic        pol;
    logic [11:0] spr;
    logic        o_a, o_b, o_i, o_step, o_step_rev;
    logic [11:0] o_position;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0..3 indexes the forward sequence 00,10,11,01.
    int m_cnt, m_phase, m_pos, m_idx, m_step, m_rev;

    quad_encoder_emulator #(
        .K_PERIOD_W(16),
        .K_POS_W   (12)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (en),
        .i_reverse      (rev),
        .i_period       (period),
        .i_polarity     (pol),
        .i_steps_per_rev(spr),
        .o_a            (o_a),
        .o_b            (o_b),
        .o_i            (o_i),
        .o_step         (o_step),
        .o_step_rev     (o_step_rev),
        .o_position     (o_position)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ab_of(input int phase);
        case (phase)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_update();
        int p, n;
        p = int'(period);
        n = int'(spr);
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_pos = 0; m_idx = 0; m_step = 0; m_rev = 0;
        end else begin
            m_step = 0;
            if (!en || p == 0) begin
                m_cnt = 0;
            end else if (m_cnt >= p - 1) begin
                m_cnt  = 0;
                m_step = 1;
                m_rev  = int'(rev);
                m_phase = rev ? (m_phase + 3) % 4 : (m_phase + 1) % 4;
                if (n == 0)
                    m_pos = rev ? (m_pos + 4095) % 4096 : (m_pos + 1) % 4096;
                else if (!rev)
                    m_pos = (m_pos >= n - 1) ? 0 : m_pos + 1;
                else
                    m_pos = (m_pos == 0 || m_pos >= n) ? n - 1 : m_pos - 1;
                m_idx = (m_pos == 0 && n != 0) ? 1 : 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic logic [16:0] exp_vec();
        logic [1:0] ab;
        ab = ab_of(m_phase);
        if (pol) ab = {ab[0], ab[1]};
        return {ab, m_idx[0], m_step[0], m_rev[0], m_pos[11:0]};
    endfunction

    function automatic logic [16:0] act_vec();
        return {o_a, o_b, o_i, o_step, o_step_rev, o_position};
    endfunction

    // Advance one clock: model follows the pre-edge inputs, outputs are read at the negedge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic setup(input logic r, input logic [15:0] p, input logic [11:0] n,
                         input logic pl);
        rst_n = 1'b0; en = 1'b1; rev = r; period = p; spr = n; pol = pl;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; rev = 1'b0; period = 16'd3; spr = 12'd5; pol = 1'b0;
        tick();
        tick();
        n_tests++;
        if (act_vec() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", act_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        int idx_hi = 0;
        setup(1'b0, 16'd4, 12'd8, 1'b0);
        for (int i = 0; i < 100; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL forward cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 3) begin
                n_tests++;
                if ({o_a, o_b, o_step, o_position} !== {2'b10, 1'b1, 12'd1}) begin
                    n_fail++;
                    $display("FAIL forward_first_step: got %b%b %b %0d want 10 1 1",
                             o_a, o_b, o_step, o_position);
                end
            end
            if (i >= 36 && o_i) idx_hi++;
        end
        n_tests++;
        if (idx_hi != 8) begin
            n_fail++;
            $display("FAIL forward_index_width: got %0d high cycles want 8", idx_hi);
        end
    endtask

    task automatic test_reverse();
        setup(1'b1, 16'd4, 12'd8, 1'b0);
        for (int i = 0; i < 70; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reverse cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 3) begin
                n_tests++;
                if ({o_a, o_b, o_step_rev, o_position} !== {2'b01, 1'b1, 12'd7}) begin
                    n_fail++;
                    $display("FAIL reverse_first_step: got %b%b %b %0d want 01 1 7",
                             o_a, o_b, o_step_rev, o_position);
                end
            end
        end
    endtask

    task automatic test_direction_change();
        int guard = 0;
        setup(1'b0, 16'd4, 12'd8, 1'b0);
        while (o_position != 12'd3 && guard < 40) begin
            tick();
            guard++;
        end
        rev   = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL dirchg cyc %0d: got %h want %h", guard, act_vec(), exp_vec());
            end
        end while (!o_step && guard < 20);
        n_tests++;
        if ({o_step, o_a, o_b, o_position} !== {1'b1, 2'b11, 12'd2}) begin
            n_fail++;
            $display("FAIL dirchg_step: got step=%b ab=%b%b pos=%0d want 1 11 2",
                     o_step, o_a, o_b, o_position);
        end
    endtask

    task automatic test_period_change();
        setup(1'b0, 16'd100, 12'd8, 1'b0);
        for (int i = 0; i < 50; i++) tick();
        period = 16'd10;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL period_shrink cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 0) begin
                n_tests++;
                if (o_step !== 1'b1) begin
                    n_fail++;
                    $display("FAIL period_shrink_immediate: got step=%b want 1", o_step);
                end
            end
        end
        period = 16'd0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec() || o_step !== 1'b0) begin
                n_fail++;
                $display("FAIL period_zero cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_steps_per_rev_change();
        int guard = 0;
        setup(1'b0, 16'd2, 12'd8, 1'b0);
        while (o_position != 12'd6 && guard < 40) begin
            tick();
            guard++;
        end
        spr = 12'd4;
        for (int i = 0; i < 2; i++) tick();
        n_tests++;
        if ({o_step, o_position, o_i} !== {1'b1, 12'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL shrink_n_wrap: got step=%b pos=%0d i=%b want 1 0 1",
                     o_step, o_position, o_i);
        end
        spr = 12'd0;
        for (int i = 0; i < 2; i++) tick();
        n_tests++;
        if ({o_step, o_position, o_i} !== {1'b1, 12'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL n_zero_step: got step=%b pos=%0d i=%b want 1 1 0",
                     o_step, o_position, o_i);
        end
        period = 16'd1;
        for (int i = 0; i < 4100; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL n_zero_wrap cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_polarity_and_reset();
        int wait_cyc = 0;
        setup(1'b0, 16'd4, 12'd8, 1'b1);
        for (int i = 0; i < 22; i++) begin
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL polarity cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 3) begin
                n_tests++;
                if ({o_a, o_b, o_position} !== {2'b01, 12'd1}) begin
                    n_fail++;
                    $display("FAIL polarity_swap: got %b%b pos=%0d want 01 1", o_a, o_b,
                             o_position);
                end
            end
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({o_a, o_b, o_i, o_step, o_step_rev, o_position} !== 17'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h want 0", act_vec());
        end
        rst_n = 1'b1;
        do begin
            tick();
            wait_cyc++;
        end while (!o_step && wait_cyc < 20);
        n_tests++;
        if (wait_cyc != 4) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d cycles want 4", wait_cyc);
        end
    endtask

    task automatic test_random();
        setup(1'b0, 16'd3, 12'd6, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                en     = ($urandom_range(7, 0) != 0);
                rev    = 1'($urandom_range(1, 0));
                period = 16'($urandom_range(6, 0));
                pol    = 1'($urandom_range(1, 0));
                spr    = 12'($urandom_range(10, 0));
            end
            rst_n = ($urandom_range(99, 0) != 0);
            tick();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rev = 1'b0; period = '0; spr = '0; pol = 1'b0;
        m_cnt = 0; m_phase = 0; m_pos = 0; m_idx = 0; m_step = 0; m_rev = 0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_reverse();
        test_direction_change();
        test_period_change();
        test_steps_per_rev_change();
        test_polarity_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
